// File: rtl/neuron_mac.sv
// Q8.8 multiply-accumulate neuron core: bias plus sum of a*w, rounded and saturated to Q8.8.
// Build option: define MAC_ROUND_EN for round-half-up output, otherwise truncation toward -inf.
module neuron_mac #(
  parameter int FRAC_BITS = 8,
  parameter int ACC_W = 40,
  parameter int MAX_LEN = 256,
  localparam int CW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   bias_in,
  input  logic [15:0]   a_in,
  input  logic [15:0]   w_in,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [15:0]   x_out,
  output logic          x_valid,
  output logic          busy,
  output logic [CW-1:0] cnt_out,
  output logic          len_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

`ifdef MAC_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1'b1) << (FRAC_BITS - 1);
`else
  localparam logic signed [ACC_W-1:0] RND = {ACC_W{1'b0}};
`endif
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

  state_t                  state_r;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [31:0]      prod_r;
  logic                    p_vld_r;
  logic [15:0]             x_out_r;
  logic                    x_valid_r;
  logic                    in_ready_r;
  logic                    busy_r;
  logic [CW-1:0]           cnt_r;
  logic                    len_err_r;

  logic signed [31:0]      prod_s;
  logic                    accept_s;
  logic                    max_beat_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] shr_s;
  logic [15:0]             sat_s;

  // Beat acceptance, product, and round/shift/saturate of the accumulator
  always_comb begin
    prod_s     = $signed(a_in) * $signed(w_in);
    accept_s   = (state_r == ACC) && in_valid && in_ready_r;
    max_beat_s = (cnt_r == CW'(MAX_LEN - 1));
    sum_s      = acc_r + RND;
    shr_s      = sum_s >>> FRAC_BITS;
    if (shr_s > SAT_MAX) begin
      sat_s = 16'h7fff;
    end else if (shr_s < SAT_MIN) begin
      sat_s = 16'h8000;
    end else begin
      sat_s = shr_s[15:0];
    end
  end

  // Control FSM with the two-stage multiply/accumulate pipeline and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      acc_r      <= {ACC_W{1'b0}};
      prod_r     <= 32'sd0;
      p_vld_r    <= 1'b0;
      x_out_r    <= 16'h0000;
      x_valid_r  <= 1'b0;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      len_err_r  <= 1'b0;
    end else begin
      x_valid_r <= 1'b0;
      p_vld_r   <= accept_s;
      if (accept_s) begin
        prod_r <= prod_s;
      end
      if (p_vld_r) begin
        acc_r <= acc_r + {{(ACC_W - 32){prod_r[31]}}, prod_r};
      end
      case (state_r)
        IDLE: begin
          // busy lingers for the single IDLE cycle that follows x_valid
          if (start) begin
            acc_r      <= {{(ACC_W - 16){bias_in[15]}}, bias_in} << FRAC_BITS;
            cnt_r      <= {CW{1'b0}};
            len_err_r  <= 1'b0;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ACC;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ACC: begin
          if (accept_s) begin
            cnt_r <= cnt_r + CW'(1'b1);
            if (in_last || max_beat_s) begin
              in_ready_r <= 1'b0;
              len_err_r  <= !in_last;
              state_r    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state_r <= OUT;
        end
        OUT: begin
          x_out_r   <= sat_s;
          x_valid_r <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign x_out    = x_out_r;
  assign x_valid  = x_valid_r;
  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign cnt_out  = cnt_r;
  assign len_err  = len_err_r;

endmodule
